// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe
//   Pipelined barrel shifter/rotator with valid/ready flow control.
//   The shifter is split into SHW log2 levels. Level i shifts by 2^i when
//   shift bit i is set, and each level has its own register. A beat therefore
//   takes SHW cycles to travel from input to output when nothing stalls.
//
//   Ports:
//     clk        clock, all logic on posedge
//     clear      synchronous active-high reset
//     in_valid   input beat valid
//     in_ready   block accepts a beat this cycle
//     in_data    operand, WIDTH bits
//     in_shift   shift/rotate amount, SHW bits
//     in_mode    00 rotr, 01 rotl, 10 logical right, 11 arithmetic right
//     out_valid  output beat valid
//     out_ready  consumer accepts the output beat
//     out_data   result, WIDTH bits
//     out_zero   out_data == 0, qualified by out_valid

// One log2 level of the shifter, plus its pipeline register.
// The level only consumes shift bit IDX. The other shift bits, the mode and the
// sign are passed on, so later levels can still use them.
module barrel_shifter_stage #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             advance,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   sh_i,
  input  logic [1:0]       mode_i,
  input  logic             sign_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   sh_o,
  output logic [1:0]       mode_o,
  output logic             sign_o
);
  localparam int AMT = 1 << IDX;

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = data_i;
    if (sh_i[IDX]) begin
      case (mode_i)
        2'b00: shifted = (data_i >> AMT) | (data_i << (WIDTH - AMT));
        2'b01: shifted = (data_i << AMT) | (data_i >> (WIDTH - AMT));
        2'b10: shifted = data_i >> AMT;
        // The fill comes from the original operand's MSB, not from the
        // current level's data. The sign is carried alongside each level.
        2'b11: shifted = (data_i >> AMT) | ({WIDTH{sign_i}} << (WIDTH - AMT));
        default: shifted = data_i;
      endcase
    end
  end

  // Data is loaded even for bubbles. Downstream logic only looks at the data
  // when vld_o is set.
  always_ff @(posedge clk) begin
    if (clear) begin
      vld_o  <= 1'b0;
      data_o <= '0;
      sh_o   <= '0;
      mode_o <= '0;
      sign_o <= 1'b0;
    end else if (advance) begin
      vld_o  <= vld_i;
      data_o <= shifted;
      sh_o   <= sh_i;
      mode_o <= mode_i;
      sign_o <= sign_i;
    end
  end
endmodule

module barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);
  // Index 0 holds the input side. Index i+1 holds the output register of
  // level i.
  logic [SHW:0]            vld_pipe;
  logic [SHW:0][WIDTH-1:0] data_pipe;
  logic [SHW:0][SHW-1:0]   sh_pipe;
  logic [SHW:0][1:0]       mode_pipe;
  logic [SHW:0]            sign_pipe;

  logic advance;

  // The whole pipe moves as one unit. Bubbles are not collapsed, so a single
  // advance signal is enough.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !clear;

  assign vld_pipe[0]  = in_valid && in_ready;
  assign data_pipe[0] = in_data;
  assign sh_pipe[0]   = in_shift;
  assign mode_pipe[0] = in_mode;
  assign sign_pipe[0] = in_data[WIDTH-1];

  for (genvar i = 0; i < SHW; i++) begin : g_stage
    barrel_shifter_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .IDX   (i)
    ) u_stage (
      .clk     (clk),
      .clear   (clear),
      .advance (advance),
      .vld_i   (vld_pipe[i]),
      .data_i  (data_pipe[i]),
      .sh_i    (sh_pipe[i]),
      .mode_i  (mode_pipe[i]),
      .sign_i  (sign_pipe[i]),
      .vld_o   (vld_pipe[i+1]),
      .data_o  (data_pipe[i+1]),
      .sh_o    (sh_pipe[i+1]),
      .mode_o  (mode_pipe[i+1]),
      .sign_o  (sign_pipe[i+1])
    );
  end

  assign out_valid = vld_pipe[SHW];
  assign out_data  = data_pipe[SHW];
  // The zero flag is derived from registered data. It holds whenever out_data
  // holds, and it is low whenever out_valid is low.
  assign out_zero  = out_valid && (out_data == '0);

  // The last level's shift, mode and sign are never read.
  logic unused_tail;
  assign unused_tail = ^{sh_pipe[SHW], mode_pipe[SHW], sign_pipe[SHW]};
endmodule
